// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
// The MEM_TIMEOUT_EN build option is consumed by mem_port_arbiter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    RESP_I,
    RESP_D
  } arb_state_e;

  localparam logic [1:0] BE_WORD = 2'b11;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;

  localparam int unsigned TIMEOUT_CYC_DEF = 64;

  function automatic logic [1:0] lane_be(input logic is_byte, input logic addr0);
    if (!is_byte) begin
      return BE_WORD;
    end
    return addr0 ? BE_HI : BE_LO;
  endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Combinational byte-lane steering for the 16-bit, two-lane data port:
// store enables/replication and load lane selection with sign/zero extension.
module byte_lane_unit
  import mem_arb_pkg::*;
(
  input  logic        addr0,
  input  logic        dm_byte,
  input  logic        dm_sext,
  input  logic [15:0] wdata,
  input  logic [15:0] rdata,
  output logic [1:0]  mem_be,
  output logic [15:0] mem_wdata,
  output logic [15:0] load_data
);

  logic [7:0] lane;

  always_comb begin
    mem_be    = lane_be(dm_byte, addr0);
    // Byte stores drive both lanes; the enables pick the one that lands.
    mem_wdata = dm_byte ? {wdata[7:0], wdata[7:0]} : wdata;
    lane      = addr0 ? rdata[15:8] : rdata[7:0];
    load_data = dm_byte ? {{8{dm_sext & lane[7]}}, lane} : rdata;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between fetch (IF) and data (MEM).
// Define MEM_TIMEOUT_EN to abort accesses that see no mem_ready for TIMEOUT_CYC cycles.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW          = 16,
  parameter int unsigned DW          = 16,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic          dm_byte,
  input  logic          dm_sext,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-2:0] mem_addr,
  output logic [1:0]    mem_be,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          stall_if,
  output logic          stall_mem,
  output logic          timeout_err
);

  arb_state_e    state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-2:0] mem_addr_q, mem_addr_d;
  logic [1:0]    mem_be_q, mem_be_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          if_ack_q, if_ack_d;
  logic          dm_ack_q, dm_ack_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;
  logic          byte_q, byte_d;
  logic          sext_q, sext_d;
  logic          a0_q, a0_d;

  logic          in_idle, busy, tmo_hit;
  logic          lane_a0, lane_byte, lane_sext;
  logic [1:0]    lane_be_w;
  logic [DW-1:0] lane_wdata, lane_load;

  assign in_idle = (state_q == IDLE);
  assign busy    = (state_q == BUSY_I) || (state_q == BUSY_D);

  // Store steering uses the live request in IDLE; load extension uses the latched one.
  assign lane_a0   = in_idle ? dm_addr[0] : a0_q;
  assign lane_byte = in_idle ? dm_byte    : byte_q;
  assign lane_sext = in_idle ? dm_sext    : sext_q;

  byte_lane_unit u_lanes (
    .addr0     (lane_a0),
    .dm_byte   (lane_byte),
    .dm_sext   (lane_sext),
    .wdata     (dm_wdata),
    .rdata     (mem_rdata),
    .mem_be    (lane_be_w),
    .mem_wdata (lane_wdata),
    .load_data (lane_load)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    byte_d      = byte_q;
    sext_d      = sext_q;
    a0_d        = a0_q;

    unique case (state_q)
      IDLE: begin
        // Data wins: its instruction is older than the one being fetched.
        if (dm_req) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr[AW-1:1];
          mem_be_d    = lane_be_w;
          mem_wdata_d = dm_we ? lane_wdata : '0;
          byte_d      = dm_byte;
          sext_d      = dm_sext;
          a0_d        = dm_addr[0];
        end else if (if_req) begin
          state_d     = BUSY_I;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr[AW-1:1];
          mem_be_d    = BE_WORD;
          mem_wdata_d = '0;
        end
      end
      BUSY_I: begin
        if (mem_ready || tmo_hit) begin
          state_d    = RESP_I;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          if_ack_d   = 1'b1;
          if_rdata_d = tmo_hit ? '0 : mem_rdata;
        end
      end
      BUSY_D: begin
        if (mem_ready || tmo_hit) begin
          state_d    = RESP_D;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          dm_ack_d   = 1'b1;
          dm_rdata_d = (tmo_hit || mem_we_q) ? '0 : lane_load;
        end
      end
      RESP_I, RESP_D: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      byte_q      <= 1'b0;
      sext_q      <= 1'b0;
      a0_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      byte_q      <= byte_d;
      sext_q      <= sext_d;
      a0_q        <= a0_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

  logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            timeout_err_q, timeout_err_d;

  // Counter sits at zero outside BUSY, so every access starts counting from zero.
  always_comb begin
    tmo_cnt_d     = '0;
    if (busy) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
    timeout_err_d = timeout_err_q | tmo_hit;
  end

  assign tmo_hit = busy && !mem_ready && (tmo_cnt_q == CntW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  logic unused_tmo;
  assign unused_tmo  = ^{TIMEOUT_CYC, busy};
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Fetches are halfword aligned; the low address bit carries no information.
  logic unused_if_a0;
  assign unused_if_a0 = if_addr[0];

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign stall_if  = if_req & ~if_ack_q;
  assign stall_mem = dm_req & ~dm_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed transactions push expected memory
// accesses and responses; a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_port_arbiter;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TCyc = 4;
`else
  localparam int unsigned TCyc = 64;
`endif

  typedef struct packed {
    logic        we;
    logic [14:0] addr;
    logic [1:0]  be;
    logic [15:0] wd;
  } mem_exp_t;

  typedef struct packed {
    logic        is_d;
    logic [15:0] rd;
  } resp_exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = '0;
  logic [15:0] if_rdata;
  logic        if_ack;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic        dm_byte = 1'b0;
  logic        dm_sext = 1'b0;
  logic [15:0] dm_addr = '0;
  logic [15:0] dm_wdata = '0;
  logic [15:0] dm_rdata;
  logic        dm_ack;
  logic        mem_req;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [1:0]  mem_be;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_ready;
  logic        stall_if;
  logic        stall_mem;
  logic        timeout_err;

  int nvec = 0;
  int nfail = 0;
  int waits_cfg = 0;
  int wcnt = 0;

  mem_exp_t  mq[$];
  resp_exp_t rq[$];

  mem_port_arbiter #(
    .AW          (16),
    .DW          (16),
    .TIMEOUT_CYC (TCyc)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_rdata    (if_rdata),
    .if_ack      (if_ack),
    .dm_req      (dm_req),
    .dm_we       (dm_we),
    .dm_byte     (dm_byte),
    .dm_sext     (dm_sext),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_rdata    (dm_rdata),
    .dm_ack      (dm_ack),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_be      (mem_be),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .stall_if    (stall_if),
    .stall_mem   (stall_mem),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Memory model: ready after waits_cfg wait-state cycles of an asserted strobe.
  assign mem_ready = mem_req && (wcnt >= waits_cfg);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wcnt <= 0;
    else if (!mem_req) wcnt <= 0;
    else if (!mem_ready) wcnt <= wcnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    nvec++;
    nfail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: checks every BUSY cycle against the expected access, and every ack.
  initial begin
    mem_exp_t  cur;
    resp_exp_t r;
    logic      prev_req;
    logic      have_cur;
    prev_req = 1'b0;
    have_cur = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (!prev_req) begin
          if (mq.size() == 0) begin
            fail_now("mem_unexpected_access");
            have_cur = 1'b0;
          end else begin
            cur      = mq.pop_front();
            have_cur = 1'b1;
          end
        end
        if (have_cur) begin
          chk("mem_we", 32'(mem_we), 32'(cur.we));
          chk("mem_addr", 32'(mem_addr), 32'(cur.addr));
          chk("mem_be", 32'(mem_be), 32'(cur.be));
          if (cur.we) chk("mem_wdata", 32'(mem_wdata), 32'(cur.wd));
        end
      end
      prev_req = mem_req;
      if (if_ack && dm_ack) begin
        fail_now("both_acks_high");
      end else if (if_ack || dm_ack) begin
        if (rq.size() == 0) begin
          fail_now("unexpected_ack");
        end else begin
          r = rq.pop_front();
          chk("ack_owner_is_dm", 32'(dm_ack), 32'(r.is_d));
          if (r.is_d) chk("dm_rdata", 32'(dm_rdata), 32'(r.rd));
          else chk("if_rdata", 32'(if_rdata), 32'(r.rd));
        end
      end
    end
  end

  // One fetch and/or one data request issued together; latencies count cycles from the
  // IDLE cycle in which the request is first presented (k=0) to the ack cycle.
  task automatic txn(input bit di, input bit dd, input bit we, input bit byt, input bit sext,
                     input logic [15:0] iaddr, input logic [15:0] daddr,
                     input logic [15:0] wdata, input logic [15:0] rdata, input int w,
                     input logic [14:0] exp_iwa, input logic [14:0] exp_dwa,
                     input logic [1:0] exp_be, input logic [15:0] exp_wd,
                     input logic [15:0] exp_drd, input int exp_dlat, input int exp_ilat);
    bit d_done;
    bit i_done;
    @(posedge clk);
    #1;
    waits_cfg = w;
    mem_rdata = rdata;
    if (dd) begin
      mq.push_back('{we, exp_dwa, exp_be, exp_wd});
      rq.push_back('{1'b1, exp_drd});
    end
    if (di) begin
      mq.push_back('{1'b0, exp_iwa, 2'b11, 16'h0000});
      rq.push_back('{1'b0, rdata});
    end
    if_req   = di;
    if_addr  = iaddr;
    dm_req   = dd;
    dm_we    = we;
    dm_byte  = byt;
    dm_sext  = sext;
    dm_addr  = daddr;
    dm_wdata = wdata;
    d_done   = !dd;
    i_done   = !di;
    for (int k = 0; k < 200 && !(d_done && i_done); k++) begin
      @(negedge clk);
      if (!d_done) begin
        chk("stall_mem", 32'(stall_mem), 32'(!dm_ack));
        if (dm_ack) begin
          d_done = 1'b1;
          chk("dm_latency", k, exp_dlat);
        end
      end
      if (!i_done) begin
        chk("stall_if", 32'(stall_if), 32'(!if_ack));
        if (if_ack) begin
          i_done = 1'b1;
          chk("if_latency", k, exp_ilat);
        end
      end
      @(posedge clk);
      #1;
      if (d_done) dm_req = 1'b0;
      if (i_done) if_req = 1'b0;
    end
    if (!(d_done && i_done)) fail_now("txn_no_ack_within_bound");
    if_req = 1'b0;
    dm_req = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_ctl"}, 32'({mem_req, mem_we, mem_be}), 32'h0);
    chk({tag, "_mem_addr_wdata"}, {1'b0, mem_addr, mem_wdata}, 32'h0);
    chk({tag, "_acks"}, 32'({if_ack, dm_ack, timeout_err}), 32'h0);
    chk({tag, "_rdata"}, {if_rdata, dm_rdata}, 32'h0);
  endtask

  initial begin
    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Fetch only: 0x0010 -> word 0x0008.
    txn(1, 0, 0, 0, 0, 16'h0010, 16'h0000, 16'h0000, 16'h1234, 0,
        15'h0008, 15'h0000, 2'b11, 16'h0000, 16'h0000, 0, 2);
    // Contention: LW 0x0020 first, then fetch 0x0100 once IDLE is reached again.
    txn(1, 1, 0, 0, 0, 16'h0100, 16'h0020, 16'h0000, 16'hBEEF, 0,
        15'h0080, 15'h0010, 2'b11, 16'h0000, 16'hBEEF, 2, 5);
    // Byte loads from 0x80FF.
    txn(0, 1, 0, 1, 1, 16'h0000, 16'h0031, 16'h0000, 16'h80FF, 0,
        15'h0000, 15'h0018, 2'b10, 16'h0000, 16'hFF80, 2, 0);
    txn(0, 1, 0, 1, 0, 16'h0000, 16'h0031, 16'h0000, 16'h80FF, 0,
        15'h0000, 15'h0018, 2'b10, 16'h0000, 16'h0080, 2, 0);
    txn(0, 1, 0, 1, 1, 16'h0000, 16'h0030, 16'h0000, 16'h80FF, 0,
        15'h0000, 15'h0018, 2'b01, 16'h0000, 16'hFFFF, 2, 0);
    // Byte stores replicate the low byte; store response data reads as zero.
    txn(0, 1, 1, 1, 0, 16'h0000, 16'h0040, 16'h12AB, 16'h9999, 0,
        15'h0000, 15'h0020, 2'b01, 16'hABAB, 16'h0000, 2, 0);
    txn(0, 1, 1, 1, 0, 16'h0000, 16'h0041, 16'h0055, 16'h9999, 0,
        15'h0000, 15'h0020, 2'b10, 16'h5555, 16'h0000, 2, 0);
    // Word store.
    txn(0, 1, 1, 0, 0, 16'h0000, 16'h0050, 16'hCAFE, 16'h7777, 0,
        15'h0000, 15'h0028, 2'b11, 16'hCAFE, 16'h0000, 2, 0);
    // Word load, odd address ignored, five wait states -> ack on cycle 7.
    txn(0, 1, 0, 0, 0, 16'h0000, 16'h0061, 16'h0000, 16'h5A5A, 5,
        15'h0000, 15'h0030, 2'b11, 16'h0000, 16'h5A5A, 7, 0);
    // Contention with wait states on both accesses.
    txn(1, 1, 1, 0, 0, 16'h0202, 16'h0084, 16'h0F0F, 16'h1111, 3,
        15'h0101, 15'h0042, 2'b11, 16'h0F0F, 16'h0000, 5, 11);
    // Odd fetch address, one wait state.
    txn(1, 0, 0, 0, 0, 16'h0013, 16'h0000, 16'h0000, 16'hA5C3, 1,
        15'h0009, 15'h0000, 2'b11, 16'h0000, 16'h0000, 0, 3);

    // Reset in the middle of a stalled data access: strobe drops at once, no ack.
    @(posedge clk);
    #1;
    waits_cfg = 100;
    mq.push_back('{1'b0, 15'h0038, 2'b11, 16'h0000});
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_byte = 1'b0;
    dm_addr = 16'h0070;
    repeat (3) @(posedge clk);
    #2;
    chk("mem_req_busy_before_reset", 32'(mem_req), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mem_req_async_reset", 32'(mem_req), 32'h0);
    dm_req = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("midreset");
    rst_n = 1'b1;
    txn(1, 0, 0, 0, 0, 16'h0400, 16'h0000, 16'h0000, 16'h3C3C, 0,
        15'h0200, 15'h0000, 2'b11, 16'h0000, 16'h0000, 0, 2);

`ifdef MEM_TIMEOUT_EN
    // Memory never answers: abort after four BUSY cycles with zero data.
    txn(0, 1, 0, 0, 0, 16'h0000, 16'h0080, 16'h0000, 16'hDEAD, 1000,
        15'h0000, 15'h0040, 2'b11, 16'h0000, 16'h0000, 5, 0);
    chk("timeout_err_set", 32'(timeout_err), 32'h1);
    repeat (4) @(negedge clk);
    chk("timeout_err_sticky", 32'(timeout_err), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("timeout_err_cleared", 32'(timeout_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
`else
    chk("timeout_err_tied_low", 32'(timeout_err), 32'h0);
`endif

    repeat (3) @(negedge clk);
    chk("mem_queue_drained", mq.size(), 0);
    chk("resp_queue_drained", rq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_watchdog (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
